// File: rtl/cpci_dma_pkg.sv
// Shared types and constants for the PCI DMA burst scheduler.
package cpci_dma_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StBackoff
   } state_e;

   localparam int unsigned PAGE_BYTES  = 4096;

   // Requester slots: four egress write channels, one ingress read channel.
   localparam int unsigned EGRESS0     = 0;
   localparam int unsigned EGRESS1     = 1;
   localparam int unsigned EGRESS2     = 2;
   localparam int unsigned EGRESS3     = 3;
   localparam int unsigned INGRESS     = 4;

   localparam int unsigned DEF_LEN_W   = 12;
   localparam int unsigned DEF_BURST_W = 6;

   function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: first set request at or after the pointer, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 5,
   parameter int unsigned IDX_W   = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   gnt,
   output logic               any
);

   // Scan from the pointer upward; the first hit wins.
   always_comb begin
      gnt = '0;
      any = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         int unsigned idx;
         idx = 32'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any && req[idx]) begin
            any = 1'b1;
            gnt = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/cpci_dma_sched.sv
// DMA scheduler: round-robin request arbitration, page-safe burst splitting and
// retry/disconnect handling in front of the PCI master engine.
module cpci_dma_sched
   import cpci_dma_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 5,
   parameter int unsigned LEN_W       = DEF_LEN_W,
   parameter int unsigned BURST_W     = DEF_BURST_W,
   parameter int unsigned MAX_BURST   = 16,
   parameter int unsigned RETRY_LIMIT = 8,
   parameter int unsigned BACKOFF_CYC = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_write,
   input  logic [NUM_REQ*32-1:0]    req_addr,
   input  logic [NUM_REQ*LEN_W-1:0] req_words,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       req_done,
   output logic [NUM_REQ-1:0]       req_err,
   output logic [2:0]               grant_id,
   output logic                     mst_start,
   output logic                     mst_write,
   output logic [31:0]              mst_addr,
   output logic [BURST_W-1:0]       mst_words,
   input  logic                     mst_busy,
   input  logic                     mst_done,
   input  logic                     mst_retry,
   input  logic [BURST_W-1:0]       mst_xfer_words
);

   localparam int unsigned CNT_W = $clog2(RETRY_LIMIT + 1);
   localparam int unsigned BO_W  = $clog2(BACKOFF_CYC + 1);

   state_e           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       grant_q, grant_d;
   logic [31:0]      addr_q, addr_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             write_q, write_d;
   logic [CNT_W-1:0] retry_q, retry_d;
   logic [BO_W-1:0]  bo_q, bo_d;

   logic [2:0]       arb_gnt;
   logic             arb_any;
   logic [31:0]      sel_addr;
   logic [LEN_W-1:0] sel_words;
   logic [31:0]      room, chunk32, n32, addr_adv;
   logic [LEN_W-1:0] rem_after;
   logic [2:0]       gnt_next, own_next;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (3)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .any (arb_any)
   );

   // Burst sizing and progress accounting; chunk is stable while the burst is out.
   always_comb begin
      sel_addr  = req_addr[arb_gnt*32 +: 32];
      sel_words = req_words[arb_gnt*LEN_W +: LEN_W];
      room      = (32'(PAGE_BYTES) - {20'd0, addr_q[11:0]}) >> 2;
      chunk32   = min_u32(min_u32(32'(rem_q), 32'(MAX_BURST)), room);
      n32       = min_u32(32'(mst_xfer_words), chunk32);
      addr_adv  = addr_q + (n32 << 2);
      rem_after = LEN_W'(32'(rem_q) - n32);
      gnt_next  = (arb_gnt == 3'(NUM_REQ - 1)) ? 3'd0 : arb_gnt + 3'd1;
      own_next  = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
   end

   // Next-state and pulse outputs.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      write_d   = write_q;
      retry_d   = retry_q;
      bo_d      = bo_q;
      req_ready = '0;
      req_done  = '0;
      req_err   = '0;
      mst_start = 1'b0;
      mst_write = 1'b0;
      mst_addr  = '0;
      mst_words = '0;
      unique case (state_q)
         StIdle: begin
            // Reset is asynchronous; keep the combinational pulses quiet while it is held.
            if (arb_any && !RST_N) begin
               grant_d = arb_gnt;
               if (sel_addr[1:0] != 2'b00 || sel_words == '0) begin
                  req_err[arb_gnt] = 1'b1;
                  ptr_d            = gnt_next;
               end else begin
                  req_ready[arb_gnt] = 1'b1;
                  addr_d             = sel_addr;
                  rem_d              = sel_words;
                  write_d            = req_write[arb_gnt];
                  retry_d            = '0;
                  state_d            = StIssue;
               end
            end
         end
         StIssue: begin
            if (!mst_busy) begin
               mst_start = 1'b1;
               mst_write = write_q;
               mst_addr  = addr_q;
               mst_words = chunk32[BURST_W-1:0];
               state_d   = StWait;
            end
         end
         StWait: begin
            if (mst_done || mst_retry) begin
               addr_d = addr_adv;
               rem_d  = rem_after;
               if (mst_done) begin
                  retry_d = '0;
                  if (rem_after == '0) begin
                     req_done[grant_q] = 1'b1;
                     ptr_d             = own_next;
                     state_d           = StIdle;
                  end else begin
                     state_d = StIssue;
                  end
               end else begin
                  retry_d = (n32 == '0) ? retry_q + 1'b1 : '0;
                  if (n32 == '0 && retry_q == CNT_W'(RETRY_LIMIT - 1)) begin
                     req_err[grant_q] = 1'b1;
                     ptr_d            = own_next;
                     retry_d          = '0;
                     state_d          = StIdle;
                  end else if (rem_after == '0) begin
                     req_done[grant_q] = 1'b1;
                     ptr_d             = own_next;
                     state_d           = StIdle;
                  end else begin
                     bo_d    = '0;
                     state_d = StBackoff;
                  end
               end
            end
         end
         StBackoff: begin
            if (bo_q == BO_W'(BACKOFF_CYC - 1)) begin
               state_d = StIssue;
            end else begin
               bo_d = bo_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign grant_id = grant_q;

   // State registers; reset drops any in-flight request silently.
   always_ff @(posedge CLK or posedge RST_N) begin
      if (RST_N) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         grant_q <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         write_q <= 1'b0;
         retry_q <= '0;
         bo_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         write_q <= write_d;
         retry_q <= retry_d;
         bo_q    <= bo_d;
      end
   end

endmodule

// File: tb/tb_cpci_dma_sched.sv
// Bench for cpci_dma_sched: request table, burst scoreboard and scripted master.
module tb_cpci_dma_sched;

   logic         CLK;
   logic         RST_N;
   logic [4:0]   req_valid, req_write;
   logic [159:0] req_addr;
   logic [59:0]  req_words;
   logic [4:0]   req_ready, req_done, req_err;
   logic [2:0]   grant_id;
   logic         mst_start, mst_write;
   logic [31:0]  mst_addr;
   logic [5:0]   mst_words;
   logic         mst_busy, mst_done, mst_retry;
   logic [5:0]   mst_xfer_words;

   typedef struct packed {
      logic [31:0] addr;
      logic [5:0]  words;
      logic        wr;
   } burst_t;

   typedef struct packed {
      logic       retry;
      logic [5:0] xfer;
   } resp_t;

   typedef struct packed {
      int unsigned      id;
      logic             wr;
      logic [31:0]      addr;
      logic [11:0]      words;
      logic             err;
      int unsigned      busy;
      int unsigned      nb;
      logic [2:0][31:0] baddr;
      logic [2:0][5:0]  bwords;
   } vec_t;

   burst_t exp_q[$];
   resp_t  resp_q[$];
   vec_t   vecs[6];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   logic   hold_resp;

   cpci_dma_sched dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .req_valid      (req_valid),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_words      (req_words),
      .req_ready      (req_ready),
      .req_done       (req_done),
      .req_err        (req_err),
      .grant_id       (grant_id),
      .mst_start      (mst_start),
      .mst_write      (mst_write),
      .mst_addr       (mst_addr),
      .mst_words      (mst_words),
      .mst_busy       (mst_busy),
      .mst_done       (mst_done),
      .mst_retry      (mst_retry),
      .mst_xfer_words (mst_xfer_words)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic set_req(input int unsigned id, input logic wr, input logic [31:0] addr,
                          input logic [11:0] words);
      req_write[id]          = wr;
      req_addr[id*32 +: 32]  = addr;
      req_words[id*12 +: 12] = words;
   endtask

   task automatic push_burst(input logic [31:0] addr, input logic [5:0] words, input logic wr);
      burst_t b;
      b.addr  = addr;
      b.words = words;
      b.wr    = wr;
      exp_q.push_back(b);
   endtask

   task automatic push_resp(input logic retry, input logic [5:0] xfer);
      resp_t r;
      r.retry = retry;
      r.xfer  = xfer;
      resp_q.push_back(r);
   endtask

   task automatic set_vec(input int i, input int unsigned id, input logic wr,
                          input logic [31:0] addr, input logic [11:0] words, input logic err,
                          input int unsigned busy, input int unsigned nb,
                          input logic [31:0] a0, input logic [5:0] w0,
                          input logic [31:0] a1, input logic [5:0] w1,
                          input logic [31:0] a2, input logic [5:0] w2);
      vecs[i].id        = id;
      vecs[i].wr        = wr;
      vecs[i].addr      = addr;
      vecs[i].words     = words;
      vecs[i].err       = err;
      vecs[i].busy      = busy;
      vecs[i].nb        = nb;
      vecs[i].baddr[0]  = a0;
      vecs[i].bwords[0] = w0;
      vecs[i].baddr[1]  = a1;
      vecs[i].bwords[1] = w1;
      vecs[i].baddr[2]  = a2;
      vecs[i].bwords[2] = w2;
   endtask

   // Waits for a completion or error pulse; both stay zero if the bound expires.
   task automatic wait_end(input int bound, output logic [4:0] d, output logic [4:0] e);
      d = '0;
      e = '0;
      for (int k = 0; k < bound; k++) begin
         @(negedge CLK);
         #1;
         if (req_done != '0 || req_err != '0) begin
            d = req_done;
            e = req_err;
            break;
         end
      end
   endtask

   // Master engine model: checks each launched burst against the scoreboard and
   // answers two cycles later, from the response script or with a full completion.
   initial begin
      int     pend;
      logic [5:0] cur_w;
      resp_t  r;
      burst_t e;
      pend           = 0;
      cur_w          = '0;
      mst_done       = 1'b0;
      mst_retry      = 1'b0;
      mst_xfer_words = '0;
      forever begin
         @(negedge CLK);
         mst_done       = 1'b0;
         mst_retry      = 1'b0;
         mst_xfer_words = '0;
         if (RST_N) begin
            pend = 0;
         end else if (pend == 1) begin
            pend = 0;
            if (resp_q.size() > 0) begin
               r              = resp_q.pop_front();
               mst_retry      = r.retry;
               mst_done       = !r.retry;
               mst_xfer_words = r.xfer;
            end else begin
               mst_done       = 1'b1;
               mst_xfer_words = cur_w;
            end
         end else if (pend > 1) begin
            pend--;
         end
         #2;
         if (mst_start) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected burst: addr 0x%0h words %0d, none expected",
                        mst_addr, mst_words);
            end else begin
               e = exp_q.pop_front();
               check("burst addr", mst_addr, e.addr);
               check("burst words", 32'(mst_words), 32'(e.words));
               check("burst write", 32'(mst_write), 32'(e.wr));
            end
            cur_w = mst_words;
            pend  = hold_resp ? 0 : 2;
         end
      end
   end

   initial begin
      vec_t       v;
      logic [4:0] d, e;
      int         grants[6];
      int         ng, rcyc, scyc;

      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_words = '0;
      mst_busy  = 1'b0;
      hold_resp = 1'b0;
      RST_N     = 1'b0;
      #2 RST_N  = 1'b1;

      // Reset state.
      repeat (2) @(negedge CLK);
      #1;
      check("reset req_ready", 32'(req_ready), 0);
      check("reset req_done", 32'(req_done), 0);
      check("reset req_err", 32'(req_err), 0);
      check("reset grant_id", 32'(grant_id), 0);
      check("reset mst_start", 32'(mst_start), 0);
      check("reset mst_addr", mst_addr, 0);
      check("reset mst_words", 32'(mst_words), 0);
      @(negedge CLK);
      RST_N = 1'b0;

      // Round-robin among requesters 0, 1 and 4, one word each.
      @(negedge CLK);
      set_req(0, 1'b1, 32'h7000_0000, 12'd1);
      set_req(1, 1'b1, 32'h7100_0000, 12'd1);
      set_req(4, 1'b0, 32'h7400_0000, 12'd1);
      for (int r = 0; r < 2; r++) begin
         push_burst(32'h7000_0000, 6'd1, 1'b1);
         push_burst(32'h7100_0000, 6'd1, 1'b1);
         push_burst(32'h7400_0000, 6'd1, 1'b0);
      end
      req_valid = 5'b10011;
      ng = 0;
      for (int k = 0; k < 300 && ng < 6; k++) begin
         #1;
         for (int b = 0; b < 5; b++) begin
            if (req_ready[b]) begin
               grants[ng] = b;
               ng++;
            end
         end
         @(negedge CLK);
      end
      req_valid = '0;
      check("rr grant 0", 32'(grants[0]), 0);
      check("rr grant 1", 32'(grants[1]), 1);
      check("rr grant 2", 32'(grants[2]), 4);
      check("rr grant 3", 32'(grants[3]), 0);
      check("rr grant 4", 32'(grants[4]), 1);
      check("rr grant 5", 32'(grants[5]), 4);
      wait_end(100, d, e);
      check("rr last done", 32'(d), 32'h10);
      check("rr bursts outstanding", exp_q.size(), 0);

      // Request table: splitting, page crossing, address wrap, ingress, rejects.
      set_vec(0, 0, 1'b1, 32'hC000_0000, 12'd40, 1'b0, 0, 3,
              32'hC000_0000, 6'd16, 32'hC000_0040, 6'd16, 32'hC000_0080, 6'd8);
      set_vec(1, 2, 1'b1, 32'hC000_0FF0, 12'd10, 1'b0, 3, 2,
              32'hC000_0FF0, 6'd4, 32'hC000_1000, 6'd6, 32'h0, 6'd0);
      set_vec(2, 3, 1'b1, 32'hFFFF_FFF8, 12'd6, 1'b0, 0, 2,
              32'hFFFF_FFF8, 6'd2, 32'h0000_0000, 6'd4, 32'h0, 6'd0);
      set_vec(3, 4, 1'b0, 32'h1000_0100, 12'd20, 1'b0, 0, 2,
              32'h1000_0100, 6'd16, 32'h1000_0140, 6'd4, 32'h0, 6'd0);
      set_vec(4, 1, 1'b1, 32'hC000_0002, 12'd5, 1'b1, 0, 0,
              32'h0, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0);
      set_vec(5, 2, 1'b1, 32'h2000_0000, 12'd0, 1'b1, 0, 0,
              32'h0, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0);
      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         @(negedge CLK);
         for (int b = 0; b < 3; b++) begin
            if (b < int'(v.nb)) push_burst(v.baddr[b], v.bwords[b], v.wr);
         end
         set_req(v.id, v.wr, v.addr, v.words);
         req_valid = 5'(1 << v.id);
         mst_busy  = (v.busy > 0);
         #1;
         check("req_ready", 32'(req_ready), v.err ? 0 : (1 << v.id));
         check("req_err", 32'(req_err), v.err ? (1 << v.id) : 0);
         @(negedge CLK);
         req_valid = '0;
         #1;
         check("grant_id", 32'(grant_id), v.id);
         check("first mst_start", 32'(mst_start), (v.err || v.busy > 0) ? 0 : 1);
         if (v.busy > 0) begin
            repeat (v.busy - 1) @(negedge CLK);
            mst_busy = 1'b0;
         end
         if (!v.err) begin
            wait_end(300, d, e);
            check("req_done", 32'(d), 1 << v.id);
            check("no req_err", 32'(e), 0);
         end else begin
            repeat (3) @(negedge CLK);
         end
         check("table bursts outstanding", exp_q.size(), 0);
      end

      // Partial disconnect: 5 of 16 words move, backoff, reissue the remaining 11.
      @(negedge CLK);
      push_burst(32'hC000_0000, 6'd16, 1'b1);
      push_burst(32'hC000_0014, 6'd11, 1'b1);
      push_resp(1'b1, 6'd5);
      set_req(0, 1'b1, 32'hC000_0000, 12'd16);
      req_valid = 5'b00001;
      #1;
      check("pd req_ready", 32'(req_ready), 1);
      @(negedge CLK);
      req_valid = '0;
      rcyc = -100;
      scyc = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge CLK);
         #1;
         if (mst_retry) begin
            rcyc = cyc;
            break;
         end
      end
      for (int k = 0; k < 50; k++) begin
         @(negedge CLK);
         #1;
         if (mst_start) begin
            scyc = cyc;
            break;
         end
      end
      check("backoff reissue gap", 32'(scyc - rcyc), 5);
      wait_end(100, d, e);
      check("pd req_done", 32'(d), 1);
      check("pd bursts outstanding", exp_q.size(), 0);

      // Zero-progress retries: progress after seven clears the count, eight more abort.
      @(negedge CLK);
      for (int k = 0; k < 8; k++) push_burst(32'h3000_0000, 6'd8, 1'b1);
      for (int k = 0; k < 8; k++) push_burst(32'h3000_0008, 6'd6, 1'b1);
      for (int k = 0; k < 7; k++) push_resp(1'b1, 6'd0);
      push_resp(1'b1, 6'd2);
      for (int k = 0; k < 8; k++) push_resp(1'b1, 6'd0);
      set_req(1, 1'b1, 32'h3000_0000, 12'd8);
      req_valid = 5'b00010;
      @(negedge CLK);
      req_valid = '0;
      wait_end(500, d, e);
      check("abort req_err", 32'(e), 32'h2);
      check("abort no req_done", 32'(d), 0);
      repeat (10) @(negedge CLK);
      check("abort bursts outstanding", exp_q.size(), 0);
      resp_q.delete();

      // Reset while a burst is outstanding; pointer (now 2) must return to 0.
      @(negedge CLK);
      hold_resp = 1'b1;
      push_burst(32'h4000_0000, 6'd16, 1'b1);
      set_req(3, 1'b1, 32'h4000_0000, 12'd16);
      req_valid = 5'b01000;
      @(negedge CLK);
      req_valid = '0;
      repeat (3) @(negedge CLK);
      #1;
      check("pre-reset grant_id", 32'(grant_id), 3);
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      check("mid reset grant_id", 32'(grant_id), 0);
      check("mid reset mst_start", 32'(mst_start), 0);
      check("mid reset mst_addr", mst_addr, 0);
      check("mid reset mst_words", 32'(mst_words), 0);
      check("mid reset req_done", 32'(req_done), 0);
      check("mid reset req_err", 32'(req_err), 0);
      repeat (2) @(negedge CLK);
      hold_resp = 1'b0;
      RST_N     = 1'b0;
      @(negedge CLK);
      push_burst(32'h5000_0000, 6'd1, 1'b1);
      set_req(0, 1'b1, 32'h5000_0000, 12'd1);
      set_req(3, 1'b1, 32'h6000_0000, 12'd1);
      req_valid = 5'b01001;
      #1;
      check("post-reset req_ready", 32'(req_ready), 1);
      @(negedge CLK);
      req_valid = '0;
      wait_end(100, d, e);
      check("post-reset req_done", 32'(d), 1);
      repeat (3) @(negedge CLK);
      check("post-reset bursts outstanding", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected test completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cpci_dma_sched.md
Name: cpci_dma_sched

Overview:
- Schedules DMA transfers between the host-memory PCI master engine and NUM_REQ requesters: 4 egress write channels plus 1 ingress read channel.
- Arbitrates round-robin among requesters.
- Splits each request into page-safe bursts no longer than MAX_BURST words and issues them to the master engine one at a time.
- Handles target retry/disconnect with partial-transfer accounting, bounded retries and backoff.

Parameters:
- NUM_REQ, 5, number of requesters (index 4 = ingress read).
- LEN_W, 12, width of request length in dwords.
- BURST_W, 6, width of burst length field.
- MAX_BURST, 16, max dwords per master burst.
- RETRY_LIMIT, 8, consecutive zero-progress retries before abort.
- BACKOFF_CYC, 4, idle cycles between a retry and the reissue.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  request pending, per requester.
- req_write  in  NUM_REQ  1 = write to host, 0 = read from host.
- req_addr  in  NUM_REQ*32  host byte address, packed.
- req_words  in  NUM_REQ*LEN_W  transfer length in dwords, packed.
- req_ready  out  NUM_REQ  1-cycle pulse: request latched.
- req_done  out  NUM_REQ  1-cycle pulse: all words moved.
- req_err  out  NUM_REQ  1-cycle pulse: request rejected or aborted.
- grant_id  out  3  index of current owner.
- mst_start  out  1  1-cycle burst launch.
- mst_write  out  1  burst direction.
- mst_addr  out  32  burst start address.
- mst_words  out  BURST_W  burst length in dwords.
- mst_busy  in  1  master engine occupied.
- mst_done  in  1  burst completed normally.
- mst_retry  in  1  burst ended by target STOP.
- mst_xfer_words  in  BURST_W  dwords actually moved; valid with done/retry.

Behaviour:
- Reset (RST_N=1, any time, including mid-burst):
  - State IDLE; all outputs 0; grant_id 0; round-robin pointer 0; retry and backoff counters 0.
  - Any in-flight request is dropped with no done/err pulse.
- States: IDLE, ISSUE, WAIT, BACKOFF.
- IDLE:
  - When any req_valid is high, choose the first set bit at or after the pointer, wrapping.
  - Same cycle: pulse req_ready[g]; latch addr, words and write; set grant_id = g.
  - If addr[1:0] != 0 or words == 0: pulse req_err[g] instead of req_ready, advance the pointer to g+1, stay in IDLE.
  - Otherwise go to ISSUE.
- ISSUE:
  - chunk = min(remaining, MAX_BURST, (4096 - addr[11:0]) >> 2).
  - When mst_busy == 0: pulse mst_start for 1 cycle with mst_addr = addr and mst_words = chunk, then go to WAIT.
  - While mst_busy is high, hold in ISSUE.
- WAIT, on mst_done:
  - n = min(mst_xfer_words, chunk); addr += 4*n; remaining -= n; retry_cnt = 0.
  - If remaining == 0: pulse req_done[g], pointer = g+1 mod NUM_REQ, go to IDLE.
  - Otherwise go to ISSUE. The same owner keeps the bus; re-arbitration happens only at request end.
- WAIT, on mst_retry:
  - Apply the same n accounting.
  - If n > 0: retry_cnt = 0. If n == 0: retry_cnt += 1.
  - If retry_cnt reaches RETRY_LIMIT: pulse req_err[g], advance the pointer, go to IDLE.
  - Else if remaining == 0: pulse req_done[g] (the disconnect landed on the last word), go to IDLE.
  - Otherwise go to BACKOFF.
- mst_done and mst_retry in the same cycle: treated as mst_done.
- BACKOFF: count BACKOFF_CYC cycles, then ISSUE.
- Latency: req_valid sampled in cycle T → req_ready at T → earliest mst_start at T+1.
- Deasserting req_valid after req_ready has no effect; the latched request completes.
- Address arithmetic is 32-bit and wraps modulo 2^32. Bursts never cross a 4 KB boundary.
- mst_xfer_words > chunk is clamped to chunk.

Decomposition:
- Package cpci_dma_pkg holds:
  - state enum;
  - PAGE_BYTES = 4096;
  - requester index constants EGRESS0..EGRESS3 = 0..3 and INGRESS = 4;
  - default widths LEN_W and BURST_W.
- Sub-module rr_arbiter: rotating-priority encoder; inputs req vector and pointer; outputs grant index and any-valid. Purely combinational; the pointer register stays in the top level.

Test Plan:
- Single write, req 0, addr 0xC0000000, 40 words, master always completes fully → bursts of 16/16/8 at 0xC0000000, 0xC0000040, 0xC0000080; one req_done[0]; mst_start first at T+1.
- Page crossing, addr 0xC0000FF0, 10 words → bursts of 4 words at 0xC0000FF0, then 6 words at 0xC0001000.
- Round-robin, req_valid = 5'b10011 continuously, each request 1 word → grant order 0, 1, 4, 0, 1, 4.
- Partial disconnect, 16-word burst, mst_retry with xfer 5 → 4 idle cycles, then reissue at addr +20 bytes with 11 words, retry_cnt = 0.
- Zero-progress retry, 8 consecutive mst_retry with xfer 0 → req_err pulse after the 8th retry, no req_done; misaligned addr 0xC0000002 → immediate req_err and no mst_start.
- Reset asserted during WAIT, then released → all outputs 0, IDLE, pointer 0; the next request is granted normally.
